// File: rtl/rdma_reg_pipe.sv
// rdma_reg_pipe: AXI4-Stream pipeline of STAGES full-throughput skid stages with occupancy count.
// Define RDMA_REG_PIPE_STATS_EN to add beat/packet/stall statistics counters.
module rdma_reg_pipe #(
    parameter int DATA_W   = 512,
    parameter int STAGES   = 2,
    parameter int HAS_LAST = 1,
    parameter int OCC_W    = 5
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
`ifdef RDMA_REG_PIPE_STATS_EN
    output logic [31:0]         stat_beats,
    output logic [31:0]         stat_pkts,
    output logic [31:0]         stat_stall,
`endif
    output logic [OCC_W-1:0]    occupancy
);
    localparam int KW = DATA_W / 8;
    localparam int PW = DATA_W + KW + 1;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

    logic [PW-1:0] pay [0:STAGES];
    logic          vld [0:STAGES];
    logic          rdy [0:STAGES];
    logic          s_hs, m_hs;
    logic [OCC_W-1:0] occ_q, occ_d;

    // keep/last are zeroed at the entry so stages carry constants when unused
    assign pay[0] = HAS_LAST != 0 ? {s_axis_tdata, s_axis_tkeep, s_axis_tlast}
                                  : {s_axis_tdata, {(KW + 1){1'b0}}};
    assign vld[0]      = s_axis_tvalid;
    assign rdy[STAGES] = m_axis_tready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        state_e        state_q, state_d;
        logic [PW-1:0] main_q, main_d, skid_q, skid_d;
        logic          in_hs, out_hs;
        assign in_hs    = vld[k] && state_q != FULL;
        assign out_hs   = state_q != EMPTY && rdy[k+1];
        assign rdy[k]   = state_q != FULL;
        assign vld[k+1] = state_q != EMPTY;
        assign pay[k+1] = main_q;
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d = BUSY;
                        main_d  = pay[k];
                    end
                end
                BUSY: begin
                    if (in_hs && !out_hs) begin
                        state_d = FULL;
                        skid_d  = pay[k];
                    end else if (out_hs && !in_hs) begin
                        state_d = EMPTY;
                    end else if (in_hs) begin
                        main_d = pay[k];
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        always_ff @(posedge aclk) begin
            if (areset) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end
    end

    // ready is held low while reset is asserted; pass-through mode stays purely combinational
    assign s_axis_tready = rdy[0] && (STAGES == 0 || !areset);
    assign m_axis_tvalid = vld[STAGES];
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = pay[STAGES];

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = m_axis_tvalid && m_axis_tready;

    always_comb occ_d = s_hs == m_hs ? occ_q : s_hs ? occ_q + 1'b1 : occ_q - 1'b1;

    always_ff @(posedge aclk) begin
        if (areset) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;

`ifdef RDMA_REG_PIPE_STATS_EN
    logic [31:0] beats_q, pkts_q, stall_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            beats_q <= '0;
            pkts_q  <= '0;
            stall_q <= '0;
        end else begin
            beats_q <= beats_q + {31'd0, m_hs};
            pkts_q  <= pkts_q + {31'd0, m_hs && (HAS_LAST == 0 || m_axis_tlast)};
            stall_q <= stall_q + {31'd0, m_axis_tvalid && !m_axis_tready};
        end
    end

    assign stat_beats = beats_q;
    assign stat_pkts  = pkts_q;
    assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_rdma_reg_pipe.sv
// tb_rdma_reg_pipe: randomized and directed checks of rdma_reg_pipe against a FIFO scoreboard model.
module tb_rdma_reg_pipe;
    typedef logic [576:0] a_beat_t;
    typedef logic [144:0] b_beat_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: defaults (512b, 2 stages, keep/last)
    logic         a_sv = 0, a_sr, a_sl = 0, a_mv, a_mr = 0, a_ml;
    logic [511:0] a_sd = '0, a_md;
    logic [63:0]  a_sk = '0, a_mk;
    logic [4:0]   a_occ;
    // B: 128b, 4 stages
    logic         b_sv = 0, b_sr, b_sl = 0, b_mv, b_mr = 0, b_ml;
    logic [127:0] b_sd = '0, b_md;
    logic [15:0]  b_sk = '0, b_mk;
    logic [4:0]   b_occ;
    // C: 32b pass-through without keep/last
    logic         c_sv = 0, c_sr, c_sl = 0, c_mv, c_mr = 0, c_ml;
    logic [31:0]  c_sd = '0, c_md;
    logic [3:0]   c_sk = '0, c_mk;
    logic [4:0]   c_occ;
`ifdef RDMA_REG_PIPE_STATS_EN
    logic [31:0]  sb [0:3], sp [0:3], ss [0:3];
    logic         d_sv = 0, d_sr, d_sl = 0, d_mv, d_mr = 0, d_ml;
    logic [31:0]  d_sd = '0, d_md;
    logic [3:0]   d_sk = '0, d_mk;
    logic [4:0]   d_occ;
`endif

    rdma_reg_pipe #(.DATA_W(512), .STAGES(2), .HAS_LAST(1), .OCC_W(5)) u_a (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
        .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
`ifdef RDMA_REG_PIPE_STATS_EN
        .stat_beats(sb[0]), .stat_pkts(sp[0]), .stat_stall(ss[0]),
`endif
        .occupancy(a_occ)
    );

    rdma_reg_pipe #(.DATA_W(128), .STAGES(4), .HAS_LAST(1), .OCC_W(5)) u_b (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
        .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
`ifdef RDMA_REG_PIPE_STATS_EN
        .stat_beats(sb[1]), .stat_pkts(sp[1]), .stat_stall(ss[1]),
`endif
        .occupancy(b_occ)
    );

    rdma_reg_pipe #(.DATA_W(32), .STAGES(0), .HAS_LAST(0), .OCC_W(5)) u_c (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(c_sv), .s_axis_tready(c_sr), .s_axis_tdata(c_sd), .s_axis_tkeep(c_sk), .s_axis_tlast(c_sl),
        .m_axis_tvalid(c_mv), .m_axis_tready(c_mr), .m_axis_tdata(c_md), .m_axis_tkeep(c_mk), .m_axis_tlast(c_ml),
`ifdef RDMA_REG_PIPE_STATS_EN
        .stat_beats(sb[2]), .stat_pkts(sp[2]), .stat_stall(ss[2]),
`endif
        .occupancy(c_occ)
    );

`ifdef RDMA_REG_PIPE_STATS_EN
    rdma_reg_pipe #(.DATA_W(32), .STAGES(1), .HAS_LAST(1), .OCC_W(5)) u_d (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(d_sv), .s_axis_tready(d_sr), .s_axis_tdata(d_sd), .s_axis_tkeep(d_sk), .s_axis_tlast(d_sl),
        .m_axis_tvalid(d_mv), .m_axis_tready(d_mr), .m_axis_tdata(d_md), .m_axis_tkeep(d_mk), .m_axis_tlast(d_ml),
        .stat_beats(sb[3]), .stat_pkts(sp[3]), .stat_stall(ss[3]),
        .occupancy(d_occ)
    );
`endif

    task automatic chk(input string tag, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference model: the pipe is a FIFO of accepted beats, occupancy = beats inside it
    a_beat_t a_q[$];
    b_beat_t b_q[$];
    int      a_acc = 0, a_emit = 0, b_acc = 0, b_emit = 0;
    logic    a_in, a_out, b_in = 0, b_out, b_stall = 0;
    b_beat_t b_held = '0;

    function automatic a_beat_t a_beat(input int k);
        return {{16{k}}, {64{1'b1}}, k[1:0] == 2'd3};
    endfunction

    task automatic a_cycle(input logic sv, input a_beat_t p, input logic mr);
        @(negedge clk);
        a_sv = sv;
        {a_sd, a_sk, a_sl} = p;
        a_mr = mr;
        #1;
        chk("a_occ", a_occ, a_q.size());
        a_out = a_mv && a_mr;
        a_in  = a_sv && a_sr;
        if (a_out) begin
            chk("a_nonempty", a_q.size() != 0, 1);
            if (a_q.size() != 0) chk("a_payload", {a_md, a_mk, a_ml}, a_q.pop_front());
            a_emit++;
        end
        if (a_in) begin
            a_q.push_back(p);
            a_acc++;
        end
    endtask

    task automatic b_cycle(input logic sv, input b_beat_t p, input logic mr);
        @(negedge clk);
        b_sv = sv;
        {b_sd, b_sk, b_sl} = p;
        b_mr = mr;
        #1;
        chk("b_occ", b_occ, b_q.size());
        chk("b_occ_max", b_occ <= 5'd8, 1);
        if (b_stall) begin
            chk("b_hold_valid", b_mv, 1);
            chk("b_hold_payload", {b_md, b_mk, b_ml}, b_held);
        end
        b_stall = b_mv && !b_mr;
        b_held  = {b_md, b_mk, b_ml};
        b_out   = b_mv && b_mr;
        b_in    = b_sv && b_sr;
        if (b_out) begin
            chk("b_nonempty", b_q.size() != 0, 1);
            if (b_q.size() != 0) chk("b_payload", {b_md, b_mk, b_ml}, b_q.pop_front());
            b_emit++;
        end
        if (b_in) begin
            b_q.push_back(p);
            b_acc++;
        end
    endtask

    int      k, n0, e0, first, last, n, nr, acc0;
    logic    sv;
    b_beat_t p;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sready", a_sr, 0);
        chk("rst_mvalid", a_mv, 0);
        chk("rst_occ", a_occ, 0);
        areset = 0;

        // single beat latency through two stages
        a_cycle(1, {{64{8'hA5}}, {64{1'b1}}, 1'b1}, 1);
        chk("lat_accept", a_q.size(), 1);
        a_cycle(0, '0, 1);
        chk("lat_mv_c1", a_mv, 0);
        a_cycle(0, '0, 1);
        chk("lat_mv_c2", a_mv, 1);
        chk("lat_data", a_md, {64{8'hA5}});
        a_cycle(0, '0, 1);
        chk("lat_mv_after", a_mv, 0);

        // backpressure fill: capacity is 2*STAGES
        k = 0;
        n0 = a_acc;
        e0 = a_emit;
        for (int c = 0; c < 10; c++) begin
            a_cycle(1, a_beat(k), 0);
            if (a_in) k++;
        end
        chk("bp_accepted", a_acc - n0, 4);
        chk("bp_sready", a_sr, 0);
        chk("bp_occ", a_occ, 4);
        for (int c = 0; c < 30 && a_emit - e0 < 8; c++) begin
            a_cycle(1, a_beat(k), 1);
            if (a_in) k++;
        end
        chk("bp_emitted", a_emit - e0, 8);
        chk("bp_resume", a_acc - n0 > 4, 1);
        for (int c = 0; c < 10 && a_q.size() != 0; c++) a_cycle(0, '0, 1);
        chk("bp_drained", a_q.size(), 0);

        // full throughput through four stages
        first = -1;
        last = -1;
        n = 0;
        nr = 0;
        for (int c = 0; c < 80; c++) begin
            b_cycle(c < 64, {96'd0, 32'(c), 16'hFFFF, c % 8 == 7}, 1);
            if (c < 64 && !b_sr) nr++;
            if (b_out) begin
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        chk("tput_ready_drop", nr, 0);
        chk("tput_beats", n, 64);
        chk("tput_span", last - first, 63);
        chk("tput_latency", first, 4);

        // random valid/ready on both sides
        acc0 = b_acc;
        sv = 0;
        p = '0;
        b_in = 0;
        for (int c = 0; c < 60000 && b_acc - acc0 < 10000; c++) begin
            if (!(sv && !b_in)) begin
                sv = 1'($urandom_range(0, 1));
                p = {$urandom, $urandom, $urandom, $urandom, 17'($urandom)};
            end
            b_cycle(sv, p, 1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 50 && b_q.size() != 0; c++) b_cycle(0, '0, 1);
        chk("rand_accepted", b_acc - acc0, 10000);
        chk("rand_drained", b_q.size(), 0);

        // reset with beats held drops them
        for (int c = 0; c < 3; c++) a_cycle(1, a_beat(200 + c), 0);
        chk("mid_held", a_q.size(), 3);
        @(negedge clk);
        areset = 1;
        a_sv = 1;
        a_mr = 1;
        #1;
        chk("mid_rst_sready_lo", a_sr, 0);
        @(negedge clk);
        areset = 0;
        a_sv = 0;
        #1;
        chk("mid_rst_mvalid", a_mv, 0);
        chk("mid_rst_occ", a_occ, 0);
        chk("mid_rst_sready_hi", a_sr, 1);
        a_q.delete();
        b_q.delete();
        b_stall = 0;
        for (int c = 0; c < 6; c++) begin
            a_cycle(0, '0, 1);
            chk("mid_no_stale", a_mv, 0);
        end

        // zero-stage pass-through
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            c_sv = 1'($urandom_range(0, 1));
            c_mr = 1'($urandom_range(0, 1));
            c_sd = $urandom;
            c_sk = 4'($urandom);
            c_sl = 1'($urandom_range(0, 1));
            #1;
            chk("pt_valid", c_mv, c_sv);
            chk("pt_ready", c_sr, c_mr);
            chk("pt_data", c_md, c_sd);
            chk("pt_keep_last", {c_mk, c_ml}, 0);
            chk("pt_occ", c_occ, 0);
        end

`ifdef RDMA_REG_PIPE_STATS_EN
        begin
            int dk, dout, stall_left;
            logic seen;
            dk = 0;
            dout = 0;
            stall_left = 10;
            seen = 0;
            for (int c = 0; c < 300 && dout < 20; c++) begin
                @(negedge clk);
                d_sv = dk < 20;
                d_sd = dk;
                d_sk = '1;
                d_sl = dk % 4 == 3;
                d_mr = !(seen && stall_left > 0);
                #1;
                if (d_sv && d_sr) dk++;
                if (d_mv && d_mr) dout++;
                if (d_mv && !d_mr) stall_left--;
                if (d_mv) seen = 1;
            end
            @(negedge clk);
            d_sv = 0;
            d_mr = 1;
            #1;
            chk("stat_beats", sb[3], 20);
            chk("stat_pkts", sp[3], 5);
            chk("stat_stall", ss[3], 10);
            areset = 1;
            @(negedge clk);
            areset = 0;
            #1;
            chk("stat_clr", {sb[3], sp[3], ss[3]}, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
